// File: rtl/lvds_link_pkg.sv
// rtl/lvds_link_pkg.sv - shared constants for the LVDS link bridge
// Purpose: register map, CTRL/ERR/STATUS bit positions and TX FSM states.
// Ports: none (package).
package lvds_link_pkg;

  // Avalon word addresses
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_ERR    = 3'd3;

  // CTRL bits
  localparam int CTRL_IE_RX    = 0;
  localparam int CTRL_IE_TX    = 1;
  localparam int CTRL_IE_ERR   = 2;
  localparam int CTRL_LOOPBACK = 3;
  localparam int CTRL_W        = 4;

  // ERR bits (write-one-to-clear)
  localparam int ERR_TX_OVF = 0;
  localparam int ERR_RX_OVF = 1;
  localparam int ERR_FRAME  = 2;
  localparam int ERR_W      = 3;

  // STATUS bits
  localparam int ST_TX_EMPTY     = 0;
  localparam int ST_TX_FULL      = 1;
  localparam int ST_RX_EMPTY     = 2;
  localparam int ST_RX_FULL      = 3;
  localparam int ST_TX_LEVEL_LSB = 8;
  localparam int ST_RX_LEVEL_LSB = 16;
  localparam int ST_LEVEL_W      = 5;

  // TX serialiser states
  localparam logic [0:0] TX_IDLE = 1'b0;
  localparam logic [0:0] TX_SEND = 1'b1;

endpackage

// File: rtl/lvds_link_fifo.sv
// rtl/lvds_link_fifo.sv - synchronous show-ahead FIFO with level/full/empty
// Purpose: word buffer for the TX and RX directions of the link bridge.
// Ports:
//   i_clk, i_rst        clock, async active-high reset
//   i_push, i_wdata     write strobe and data (ignored when full unless popping)
//   i_pop               read strobe (ignored when empty)
//   o_rdata             head entry, valid whenever o_empty is low
//   o_level             number of stored entries
//   o_full, o_empty     status flags
module lvds_link_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_wdata,
  input  logic                       i_pop,
  output logic [W-1:0]               o_rdata,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_do_push;
  logic          w_do_pop;

  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        r_level <= r_level + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/lvds_link_nios_bridge.sv
// rtl/lvds_link_nios_bridge.sv - Avalon-MM to LVDS beat link endpoint
// Purpose: buffers CPU words in TX/RX FIFOs, serialises each word into
// DATA_W/LANE_W beats (LS first, sof on beat 0), reassembles received beats,
// with ready flow control, internal loopback and a level interrupt.
// Ports:
//   i_clk, i_rst                      clock, async active-high reset
//   i_address/i_read/i_write          Avalon slave (read latency 1)
//   i_writedata, o_readdata           Avalon data
//   o_irq                             level interrupt
//   o_tx_out/o_tx_valid/o_tx_sof      TX beat to SERDES
//   i_rdy_from_recv                   far end can take one word
//   i_rx_in/i_rx_valid/i_rx_sof       RX beat from SERDES
//   o_rdy_for_trans                   this end can take one word
//   o_led                             low byte of last received word
module lvds_link_nios_bridge
  import lvds_link_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANE_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [2:0]        i_address,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [31:0]       i_writedata,
  output logic [31:0]       o_readdata,
  output logic              o_irq,
  output logic [LANE_W-1:0] o_tx_out,
  output logic              o_tx_valid,
  output logic              o_tx_sof,
  input  logic              i_rdy_from_recv,
  input  logic [LANE_W-1:0] i_rx_in,
  input  logic              i_rx_valid,
  input  logic              i_rx_sof,
  output logic              o_rdy_for_trans,
  output logic [7:0]        o_led
);

  localparam int BEATS = DATA_W / LANE_W;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Register file
  logic [CTRL_W-1:0] r_ctrl;
  logic [ERR_W-1:0]  r_err;
  logic [31:0]       r_readdata;
  logic              r_rdy_for_trans;
  logic [7:0]        r_led;
  logic [31:0]       w_status;

  // FIFO interfaces
  logic              w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic [DATA_W-1:0] w_tx_rdata;
  logic [LW-1:0]     w_tx_level;
  logic              w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic [DATA_W-1:0] w_rx_rdata;
  logic [LW-1:0]     w_rx_level;

  // Serialiser
  logic [0:0]        r_tx_state;
  logic [DATA_W-1:0] r_tx_shift;
  logic [CW-1:0]     r_tx_cnt;
  logic [LANE_W-1:0] r_tx_out;
  logic              r_tx_valid;
  logic              r_tx_sof;
  logic              w_rdy_eff;
  logic              w_tx_last;
  logic              w_tx_start;

  // Assembler
  logic                     r_rx_active;
  logic [CW-1:0]            r_rx_cnt;
  logic [DATA_W-LANE_W-1:0] r_rx_word;
  logic [LANE_W-1:0]        w_rx_beat;
  logic                     w_rx_valid;
  logic                     w_rx_sof;
  logic                     w_rx_last;
  logic [DATA_W-1:0]        w_rx_word;

  // Error events
  logic w_wr_data, w_rd_data, w_wr_ctrl, w_wr_err;
  logic w_tx_ovf, w_rx_ovf, w_frame_err;

  assign w_wr_data = i_write && (i_address == ADDR_DATA);
  assign w_wr_ctrl = i_write && (i_address == ADDR_CTRL);
  assign w_wr_err  = i_write && (i_address == ADDR_ERR);
  assign w_rd_data = i_read  && (i_address == ADDR_DATA);

  assign w_tx_push = w_wr_data;
  assign w_tx_ovf  = w_wr_data && w_tx_full && !w_tx_pop;
  assign w_rx_pop  = w_rd_data && !w_rx_empty;

  lvds_link_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_tx_push),
    .i_wdata (i_writedata[DATA_W-1:0]),
    .i_pop   (w_tx_pop),
    .o_rdata (w_tx_rdata),
    .o_level (w_tx_level),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  lvds_link_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_rx_push),
    .i_wdata (w_rx_word),
    .i_pop   (w_rx_pop),
    .o_rdata (w_rx_rdata),
    .o_level (w_rx_level),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  // ---------------- TX serialiser ----------------
  // In loopback the far end is ourselves, so our own RX ready gates TX.
  assign w_rdy_eff  = r_ctrl[CTRL_LOOPBACK] ? r_rdy_for_trans : i_rdy_from_recv;
  assign w_tx_last  = (r_tx_state == TX_SEND) && (r_tx_cnt == CW'(BEATS-1));
  // Starting from the last beat lets consecutive words go out with no bubble.
  assign w_tx_start = ((r_tx_state == TX_IDLE) || w_tx_last) && !w_tx_empty && w_rdy_eff;
  assign w_tx_pop   = w_tx_start;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_shift <= '0;
      r_tx_cnt   <= '0;
      r_tx_out   <= '0;
      r_tx_valid <= 1'b0;
      r_tx_sof   <= 1'b0;
    end else if (w_tx_start) begin
      r_tx_state <= TX_SEND;
      r_tx_shift <= w_tx_rdata >> LANE_W;
      r_tx_cnt   <= '0;
      r_tx_out   <= w_tx_rdata[LANE_W-1:0];
      r_tx_valid <= 1'b1;
      r_tx_sof   <= 1'b1;
    end else if (r_tx_state == TX_SEND) begin
      if (w_tx_last) begin
        r_tx_state <= TX_IDLE;
        r_tx_out   <= '0;
        r_tx_valid <= 1'b0;
        r_tx_sof   <= 1'b0;
      end else begin
        r_tx_shift <= r_tx_shift >> LANE_W;
        r_tx_cnt   <= r_tx_cnt + 1'b1;
        r_tx_out   <= r_tx_shift[LANE_W-1:0];
        r_tx_sof   <= 1'b0;
      end
    end
  end

  assign o_tx_out   = r_tx_out;
  assign o_tx_valid = r_tx_valid;
  assign o_tx_sof   = r_tx_sof;

  // ---------------- RX assembler ----------------
  assign w_rx_beat  = r_ctrl[CTRL_LOOPBACK] ? r_tx_out   : i_rx_in;
  assign w_rx_valid = r_ctrl[CTRL_LOOPBACK] ? r_tx_valid : i_rx_valid;
  assign w_rx_sof   = r_ctrl[CTRL_LOOPBACK] ? r_tx_sof   : i_rx_sof;

  // r_rx_cnt is the index of the next beat expected.
  assign w_rx_last   = r_rx_active && (r_rx_cnt == CW'(BEATS-1));
  assign w_rx_push   = w_rx_valid && !w_rx_sof && w_rx_last;
  // The final beat is taken straight from the lane so the word pushes this cycle.
  assign w_rx_word   = {w_rx_beat, r_rx_word};
  assign w_rx_ovf    = w_rx_push && w_rx_full && !w_rx_pop;
  // sof while mid-word, or a non-sof beat while idle, is a framing error.
  assign w_frame_err = w_rx_valid && (w_rx_sof ? r_rx_active : !r_rx_active);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_active <= 1'b0;
      r_rx_cnt    <= '0;
      r_rx_word   <= '0;
      r_led       <= '0;
    end else if (w_rx_valid) begin
      if (w_rx_sof) begin
        r_rx_active              <= 1'b1;
        r_rx_cnt                 <= CW'(1);
        r_rx_word[LANE_W-1:0]    <= w_rx_beat;
      end else if (r_rx_active) begin
        if (w_rx_last) begin
          r_rx_active <= 1'b0;
          r_rx_cnt    <= '0;
          r_led       <= w_rx_word[7:0];
        end else begin
          r_rx_word[r_rx_cnt*LANE_W +: LANE_W] <= w_rx_beat;
          r_rx_cnt                             <= r_rx_cnt + 1'b1;
        end
      end
    end
  end

  assign o_led = r_led;

  // ---------------- Registers ----------------
  always_comb begin
    w_status = '0;
    w_status[ST_TX_EMPTY] = w_tx_empty;
    w_status[ST_TX_FULL]  = w_tx_full;
    w_status[ST_RX_EMPTY] = w_rx_empty;
    w_status[ST_RX_FULL]  = w_rx_full;
    w_status[ST_TX_LEVEL_LSB +: ST_LEVEL_W] = ST_LEVEL_W'(w_tx_level);
    w_status[ST_RX_LEVEL_LSB +: ST_LEVEL_W] = ST_LEVEL_W'(w_rx_level);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ctrl          <= '0;
      r_err           <= '0;
      r_readdata      <= '0;
      r_rdy_for_trans <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_ctrl <= i_writedata[CTRL_W-1:0];
      end
      // New error events win over a simultaneous clear.
      r_err <= (r_err & ~(w_wr_err ? i_writedata[ERR_W-1:0] : {ERR_W{1'b0}}))
             | {w_frame_err, w_rx_ovf, w_tx_ovf};
      // Two free slots: one for the word that may already be in flight.
      r_rdy_for_trans <= (w_rx_level <= LW'(DEPTH-2));
      if (i_read) begin
        case (i_address)
          ADDR_DATA:   r_readdata <= w_rx_empty ? 32'h0 : 32'(w_rx_rdata);
          ADDR_STATUS: r_readdata <= w_status;
          ADDR_CTRL:   r_readdata <= 32'(r_ctrl);
          ADDR_ERR:    r_readdata <= 32'(r_err);
          default:     r_readdata <= 32'h0;
        endcase
      end
    end
  end

  assign o_readdata      = r_readdata;
  assign o_rdy_for_trans = r_rdy_for_trans;
  assign o_irq = (r_ctrl[CTRL_IE_RX]  && !w_rx_empty)
               | (r_ctrl[CTRL_IE_TX]  &&  w_tx_empty)
               | (r_ctrl[CTRL_IE_ERR] && (|r_err));

endmodule

// File: tb/tb_lvds_link_nios_bridge.sv
// tb/tb_lvds_link_nios_bridge.sv - scoreboard bench for lvds_link_nios_bridge
module tb_lvds_link_nios_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  addr;
  logic        rd, wr;
  logic [31:0] wdata;
  logic [31:0] o_readdata;
  logic        o_irq;
  logic [3:0]  o_tx_out;
  logic        o_tx_valid, o_tx_sof;
  logic        rdy_recv;
  logic [3:0]  rx_in;
  logic        rx_valid, rx_sof;
  logic        o_rdy_for_trans;
  logic [7:0]  o_led;

  always #5 clk = ~clk;

  lvds_link_nios_bridge dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_address       (addr),
    .i_read          (rd),
    .i_write         (wr),
    .i_writedata     (wdata),
    .o_readdata      (o_readdata),
    .o_irq           (o_irq),
    .o_tx_out        (o_tx_out),
    .o_tx_valid      (o_tx_valid),
    .o_tx_sof        (o_tx_sof),
    .i_rdy_from_recv (rdy_recv),
    .i_rx_in         (rx_in),
    .i_rx_valid      (rx_valid),
    .i_rx_sof        (rx_sof),
    .o_rdy_for_trans (o_rdy_for_trans),
    .o_led           (o_led)
  );

  typedef struct {
    logic [3:0] beat;
    logic       sof;
  } beat_t;

  int          total = 0;
  int          bad   = 0;
  beat_t       exp_beats[$];
  logic [31:0] exp_rd[$];
  logic [31:0] rx_q[$];
  logic [2:0]  m_err;
  logic        rd_d1 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: readdata one cycle after a read, tx beats whenever valid.
  always @(posedge clk) rd_d1 <= rd && !rst;

  always @(negedge clk) begin : monitor
    beat_t e;
    logic [31:0] er;
    if (!rst && rd_d1) begin
      if (exp_rd.size() == 0) begin
        total++; bad++;
        $display("FAIL readdata_unexpected: got %h expected none", o_readdata);
      end else begin
        er = exp_rd.pop_front();
        check("readdata", o_readdata, er);
      end
    end
    if (!rst && o_tx_valid) begin
      if (exp_beats.size() == 0) begin
        total++; bad++;
        $display("FAIL tx_beat_unexpected: got %h expected none", o_tx_out);
      end else begin
        e = exp_beats.pop_front();
        check("tx_beat", {27'b0, o_tx_sof, o_tx_out}, {27'b0, e.sof, e.beat});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    cyc();
    wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] a, input logic [31:0] e);
    addr = a; rd = 1'b1;
    exp_rd.push_back(e);
    cyc();
    rd = 1'b0;
  endtask

  task automatic rd_data();
    logic [31:0] e;
    e = (rx_q.size() != 0) ? rx_q.pop_front() : 32'h0;
    rd_reg(3'd0, e);
  endtask

  function automatic logic [31:0] status(input int txl, input int rxl);
    logic [31:0] s;
    s = 32'h0;
    s[0] = (txl == 0);
    s[1] = (txl == 16);
    s[2] = (rxl == 0);
    s[3] = (rxl == 16);
    s[12:8]  = txl[4:0];
    s[20:16] = rxl[4:0];
    return s;
  endfunction

  // Word goes on the wire as 8 nibbles, least significant first.
  task automatic push_beats(input logic [31:0] w);
    beat_t b;
    for (int i = 0; i < 8; i++) begin
      b.beat = w[4*i +: 4];
      b.sof  = (i == 0);
      exp_beats.push_back(b);
    end
  endtask

  task automatic wait_tx_idle();
    int n = 0;
    while ((exp_beats.size() != 0 || o_tx_valid) && n < 400) begin
      cyc(); n++;
    end
    check("tx_drain_timeout", n >= 400, 0);
    repeat (3) cyc();
  endtask

  task automatic wait_tx_valid();
    int n = 0;
    while (!o_tx_valid && n < 20) begin
      cyc(); n++;
    end
    check("tx_start_timeout", o_tx_valid, 1);
  endtask

  task automatic rx_beat(input logic [3:0] b, input logic s);
    rx_in = b; rx_valid = 1'b1; rx_sof = s;
    cyc();
    rx_valid = 1'b0; rx_sof = 1'b0;
    repeat ($urandom_range(0, 2)) cyc();
  endtask

  task automatic rx_word(input logic [31:0] w);
    for (int i = 0; i < 8; i++) rx_beat(w[4*i +: 4], i == 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int seen;
    int nw;
    addr = 0; rd = 0; wr = 0; wdata = 0;
    rdy_recv = 0; rx_in = 0; rx_valid = 0; rx_sof = 0;
    m_err = 0;

    // 1. reset state
    #1;
    check("reset_outputs", {o_tx_valid, o_tx_sof, o_rdy_for_trans, o_irq, o_led, o_tx_out},
          16'h0);
    check("reset_readdata", o_readdata, 32'h0);
    repeat (3) cyc();
    rst = 0;
    cyc(); cyc();
    check("rdy_after_reset", o_rdy_for_trans, 1);
    check("tx_valid_idle", o_tx_valid, 0);
    check("irq_idle", o_irq, 0);
    rd_reg(3'd1, 32'h5);
    wr_reg(3'd2, 32'h2);
    check("irq_tx_empty", o_irq, 1);
    wr_reg(3'd2, 32'h0);
    check("irq_off", o_irq, 0);

    // 2. loopback single word
    wr_reg(3'd2, 32'h9);
    w = 32'hDEADBEEF;
    push_beats(w); rx_q.push_back(w);
    wr_reg(3'd0, w);
    wait_tx_idle();
    check("irq_rx_nonempty", o_irq, 1);
    check("led_deadbeef", o_led, 8'hEF);
    rd_data();
    check("irq_rx_drained", o_irq, 0);
    rd_reg(3'd1, 32'h5);

    // random loopback bursts
    for (int k = 0; k < 8; k++) begin
      nw = $urandom_range(1, 3);
      for (int j = 0; j < nw; j++) begin
        w = $urandom;
        push_beats(w); rx_q.push_back(w);
        wr_reg(3'd0, w);
      end
      wait_tx_idle();
      check("led_loop", o_led, w[7:0]);
      rd_reg(3'd1, status(0, rx_q.size()));
      check("irq_loop", o_irq, rx_q.size() != 0);
      while (rx_q.size() > 8) rd_data();
    end
    while (rx_q.size() != 0) rd_data();
    rd_data();
    rd_reg(3'd1, 32'h5);

    // 3. hold-off then contiguous burst of 3 words
    wr_reg(3'd2, 32'h0);
    rdy_recv = 0;
    for (int j = 0; j < 3; j++) begin
      w = $urandom;
      push_beats(w);
      wr_reg(3'd0, w);
    end
    seen = 0;
    repeat (20) begin
      if (o_tx_valid) seen++;
      cyc();
    end
    check("no_tx_without_rdy", seen, 0);
    rdy_recv = 1;
    wait_tx_valid();
    seen = 0;
    for (int j = 0; j < 24; j++) begin
      if (o_tx_valid) seen++;
      cyc();
    end
    check("contiguous_beats", seen, 24);
    check("tx_stops_after_burst", o_tx_valid, 0);
    wait_tx_idle();

    // 4. TX overflow with far end not ready
    rdy_recv = 0;
    for (int j = 0; j < 17; j++) begin
      w = $urandom;
      if (j < 16) push_beats(w);
      else m_err[0] = 1'b1;
      wr_reg(3'd0, w);
    end
    rd_reg(3'd1, status(16, 0));
    rd_reg(3'd3, 32'(m_err));
    wr_reg(3'd2, 32'h4);
    check("irq_err", o_irq, 1);
    wr_reg(3'd3, 32'h1); m_err = 0;
    rd_reg(3'd3, 32'h0);
    check("irq_err_cleared", o_irq, 0);
    wr_reg(3'd2, 32'h0);
    rdy_recv = 1;
    wait_tx_idle();
    rdy_recv = 0;
    rd_reg(3'd1, 32'h5);

    // 5. RX framing errors
    rx_beat(4'h3, 0);
    m_err[2] = 1'b1;
    rx_beat(4'h1, 1); rx_beat(4'h2, 0); rx_beat(4'h3, 0); rx_beat(4'h4, 0);
    w = 32'h12345678;
    rx_word(w); rx_q.push_back(w);
    check("led_12345678", o_led, 8'h78);
    rd_reg(3'd3, 32'(m_err));
    rd_data();
    wr_reg(3'd3, 32'h7); m_err = 0;
    rd_reg(3'd3, 32'h0);

    // RX overflow via pins
    for (int j = 0; j < 17; j++) begin
      w = $urandom;
      if (rx_q.size() < 16) rx_q.push_back(w);
      else m_err[1] = 1'b1;
      rx_word(w);
    end
    check("led_last_rx", o_led, w[7:0]);
    check("rdy_low_when_full", o_rdy_for_trans, 0);
    rd_reg(3'd1, status(0, 16));
    rd_reg(3'd3, 32'(m_err));
    while (rx_q.size() != 0) rd_data();
    rd_reg(3'd1, 32'h5);
    check("rdy_back", o_rdy_for_trans, 1);
    wr_reg(3'd3, 32'h7); m_err = 0;

    // 6. reset during SEND
    rdy_recv = 1;
    w = $urandom;
    push_beats(w);
    wr_reg(3'd0, w);
    wait_tx_valid();
    repeat (4) cyc();
    rst = 1;
    #1;
    check("rst_tx_valid", o_tx_valid, 0);
    check("rst_rdy_led", {o_rdy_for_trans, o_led}, 9'h0);
    exp_beats.delete(); rx_q.delete(); m_err = 0;
    repeat (2) cyc();
    rst = 0;
    rdy_recv = 0;
    cyc();
    rd_reg(3'd1, 32'h5);
    rd_reg(3'd3, 32'h0);
    repeat (5) cyc();
    check("scoreboard_rd_empty", exp_rd.size(), 0);
    check("scoreboard_beats_empty", exp_beats.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
